// File: rtl/jelly3_axi4l_write_sequencer.sv
// AXI4-Lite master replaying a table of register writes.
// Each entry: address, data and idle cycles after its response.
module jelly3_axi4l_write_sequencer #(
  parameter int ADDR_BITS      = 40,
  parameter int DATA_BITS      = 32,
  parameter int STRB_BITS      = DATA_BITS / 8,
  parameter int NUM            = 8,
  parameter int INDEX_BITS     = ($clog2(NUM) > 1) ? $clog2(NUM) : 1,
  parameter int WAIT_BITS      = 16,
  parameter bit ABORT_ON_ERROR = 1'b1
) (
  input  logic                      aresetn,
  input  logic                      aclk,
  input  logic                      start,
  input  logic [INDEX_BITS:0]       count,
  input  logic [NUM*ADDR_BITS-1:0]  table_addr,
  input  logic [NUM*DATA_BITS-1:0]  table_data,
  input  logic [NUM*WAIT_BITS-1:0]  table_wait,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic [INDEX_BITS-1:0]     err_index,
  output logic [ADDR_BITS-1:0]      m_axi4l_awaddr,
  output logic [2:0]                m_axi4l_awprot,
  output logic                      m_axi4l_awvalid,
  input  logic                      m_axi4l_awready,
  output logic [DATA_BITS-1:0]      m_axi4l_wdata,
  output logic [STRB_BITS-1:0]      m_axi4l_wstrb,
  output logic                      m_axi4l_wvalid,
  input  logic                      m_axi4l_wready,
  input  logic [1:0]                m_axi4l_bresp,
  input  logic                      m_axi4l_bvalid,
  output logic                      m_axi4l_bready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  logic [ADDR_BITS-1:0] addr_a [NUM];
  logic [DATA_BITS-1:0] data_a [NUM];
  logic [WAIT_BITS-1:0] wait_a [NUM];

  for (genvar i = 0; i < NUM; i++) begin : g_tbl
    assign addr_a[i] = table_addr[i*ADDR_BITS +: ADDR_BITS];
    assign data_a[i] = table_data[i*DATA_BITS +: DATA_BITS];
    assign wait_a[i] = table_wait[i*WAIT_BITS +: WAIT_BITS];
  end

  logic [1:0]            state_q, state_d;
  logic [INDEX_BITS-1:0] index_q, index_d;
  logic [INDEX_BITS:0]   count_q, count_d;
  logic                  error_q, error_d;
  logic [INDEX_BITS-1:0] err_index_q, err_index_d;
  logic                  done_q, done_d;
  logic                  awvalid_q, awvalid_d;
  logic                  wvalid_q, wvalid_d;
  logic [ADDR_BITS-1:0]  awaddr_q, awaddr_d;
  logic [DATA_BITS-1:0]  wdata_q, wdata_d;
  logic [WAIT_BITS-1:0]  wait_q, wait_d;

  logic [INDEX_BITS:0]   idx_p1;
  logic [INDEX_BITS-1:0] nidx;
  logic                  last;
  logic                  load;
  logic                  fin;

  assign idx_p1 = {1'b0, index_q} + (INDEX_BITS+1)'(1);
  assign last   = (idx_p1 == count_q);
  assign nidx   = (state_q == ST_IDLE) ? '0 : idx_p1[INDEX_BITS-1:0];

  always_comb begin
    state_d     = state_q;
    index_d     = index_q;
    count_d     = count_q;
    error_d     = error_q;
    err_index_d = err_index_q;
    done_d      = 1'b0;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    awaddr_d    = awaddr_q;
    wdata_d     = wdata_q;
    wait_d      = wait_q;
    load        = 1'b0;
    fin         = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          count_d     = count;
          error_d     = 1'b0;
          err_index_d = '0;
          index_d     = '0;
          if (count == '0) fin = 1'b1;
          else             load = 1'b1;
        end
      end
      ST_WRITE: begin
        if (awvalid_q && m_axi4l_awready) awvalid_d = 1'b0;
        if (wvalid_q && m_axi4l_wready)   wvalid_d = 1'b0;
        if ((!awvalid_q || m_axi4l_awready) &&
            (!wvalid_q || m_axi4l_wready)) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (m_axi4l_bvalid) begin
          if (m_axi4l_bresp[1] && !error_q) begin
            error_d     = 1'b1;
            err_index_d = index_q;
          end
          if (m_axi4l_bresp[1] && ABORT_ON_ERROR) begin
            fin = 1'b1;
          end else if (wait_a[index_q] != '0) begin
            state_d = ST_WAIT;
            wait_d  = wait_a[index_q] - WAIT_BITS'(1);
          end else if (last) begin
            fin = 1'b1;
          end else begin
            load = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q != '0) wait_d = wait_q - WAIT_BITS'(1);
        else if (last)    fin = 1'b1;
        else              load = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
    if (fin) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end
    // both channels launch together from the registered entry
    if (load) begin
      state_d   = ST_WRITE;
      index_d   = nidx;
      awaddr_d  = addr_a[nidx];
      wdata_d   = data_a[nidx];
      awvalid_d = 1'b1;
      wvalid_d  = 1'b1;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      count_q     <= '0;
      error_q     <= 1'b0;
      err_index_q <= '0;
      done_q      <= 1'b0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      count_q     <= count_d;
      error_q     <= error_d;
      err_index_q <= err_index_d;
      done_q      <= done_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      wait_q      <= wait_d;
    end
  end

  assign busy            = (state_q != ST_IDLE);
  assign done            = done_q;
  assign error           = error_q;
  assign err_index       = err_index_q;
  assign m_axi4l_awaddr  = awaddr_q;
  assign m_axi4l_awprot  = 3'b000;
  assign m_axi4l_awvalid = awvalid_q;
  assign m_axi4l_wdata   = wdata_q;
  assign m_axi4l_wstrb   = '1;
  assign m_axi4l_wvalid  = wvalid_q;
  assign m_axi4l_bready  = (state_q == ST_RESP);

endmodule
